// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: synchronize, debounce, press pulses
// and optional auto-repeat. Ports: clk_clk, reset_reset_n, btn_raw_n[1:0]
// (active-low raw buttons), interrupbutton_pulse (ch0), hour_changer_pulse
// (ch1), btn_level[1:0] (debounced, 1 = pressed).
module button_conditioner #(
  parameter int         CLK_HZ          = 50000000,
  parameter int         DEBOUNCE_MS     = 20,
  parameter int         REPEAT_DELAY_MS = 500,
  parameter int         REPEAT_RATE_MS  = 100,
  parameter logic [1:0] REPEAT_EN       = 2'b10
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [1:0] btn_raw_n,
  output logic       interrupbutton_pulse,
  output logic       hour_changer_pulse,
  output logic [1:0] btn_level
);

  localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int RD_CYC = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RR_CYC = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int T_MAX  = (RD_CYC > RR_CYC) ? RD_CYC : RR_CYC;
  localparam int DBW    = $clog2(DB_CYC);
  localparam int TW     = $clog2(T_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  logic [1:0] pulse;
  logic [1:0] level;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [1:0]     sync;
    logic           stable;
    logic [DBW-1:0] cnt;
    logic [TW-1:0]  tmr;
    state_t         st;
    logic           pls;
    logic           seen;
    logic           flip;

    // synchronized level, converted to active-high
    assign seen = ~sync[1];
    // last mismatch cycle of a full debounce window
    assign flip = (seen != stable) &&
                  (cnt == DBW'(DB_CYC - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        sync   <= 2'b11;
        stable <= 1'b0;
        cnt    <= '0;
        tmr    <= '0;
        st     <= S_IDLE;
        pls    <= 1'b0;
      end else begin
        sync <= {sync[0], btn_raw_n[c]};
        pls  <= 1'b0;

        if (seen == stable) begin
          cnt <= '0;
        end else if (flip) begin
          cnt    <= '0;
          stable <= seen;
        end else begin
          cnt <= cnt + 1'b1;
        end

        if (flip && seen) begin
          pls <= 1'b1;
          tmr <= '0;
          st  <= REPEAT_EN[c] ? S_DELAY : S_IDLE;
        end else if (flip) begin
          // release wins over a timer expiring on the same edge
          tmr <= '0;
          st  <= S_IDLE;
        end else begin
          unique case (st)
            S_IDLE: tmr <= '0;
            S_DELAY: begin
              if (tmr == TW'(RD_CYC - 1)) begin
                pls <= 1'b1;
                tmr <= '0;
                st  <= S_REPEAT;
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
            S_REPEAT: begin
              if (tmr == TW'(RR_CYC - 1)) begin
                pls <= 1'b1;
                tmr <= '0;
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
            default: begin
              tmr <= '0;
              st  <= S_IDLE;
            end
          endcase
        end
      end
    end

    assign pulse[c] = pls;
    assign level[c] = stable;
  end

  assign interrupbutton_pulse = pulse[0];
  assign hour_changer_pulse   = pulse[1];
  assign btn_level            = level;

endmodule
